// File: rtl/messbauer_pkg.sv
// Shared definitions for the Moessbauer discriminator counter and the
// discriminator signal generator: state encoding and default sizes.
package messbauer_pkg;

  localparam int DEFAULT_COUNTER_WIDTH      = 16;
  localparam int DEFAULT_MAX_PULSE_DURATION = 32;
  localparam int DEFAULT_SYNC_STAGES        = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_LOWER_HIGH = 2'b01,
    ST_UPPER_SEEN = 2'b10,
    ST_ABORT      = 2'b11
  } disc_state_t;

endpackage

// File: rtl/messbauer_sync_edge.sv
// Single-bit multi-flop synchronizer followed by a one-flop rise/fall detector.
// Edges are suppressed until the pipeline holds real samples after reset.
module messbauer_sync_edge
  import messbauer_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic aclk,
  input  logic areset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [SYNC_STAGES:0]   fill_r;

  // Synchronizer chain, edge-detect history and pipeline-filled marker.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      fill_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
      fill_r <= {fill_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // A level already present at reset release is history, not an edge.
  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = fill_r[SYNC_STAGES] & level & ~prev_r;
  assign fall  = fill_r[SYNC_STAGES] & ~level & prev_r;

endmodule

// File: rtl/messbauer_diff_discriminator_counter.sv
// Differential discriminator event counter: classifies lower/upper threshold
// pulses as accepted or rejected and reports saturating per-channel counts.
module messbauer_diff_discriminator_counter
  import messbauer_pkg::*;
#(
  parameter int COUNTER_WIDTH      = DEFAULT_COUNTER_WIDTH,
  parameter int MAX_PULSE_DURATION = DEFAULT_MAX_PULSE_DURATION,
  parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     channel,
  input  logic                     lower_threshold,
  input  logic                     upper_threshold,
  output logic [COUNTER_WIDTH-1:0] channel_count,
  output logic [COUNTER_WIDTH-1:0] rejected_count,
  output logic                     count_valid,
  output logic                     overflow,
  output logic                     protocol_error
);

  localparam int DUR_W = $clog2(MAX_PULSE_DURATION + 1);
  localparam logic [DUR_W-1:0]         DUR_LAST = DUR_W'(MAX_PULSE_DURATION - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;

  // Returns {lost_event, next_value}; holds at CNT_MAX instead of wrapping.
  function automatic logic [COUNTER_WIDTH:0] sat_inc(
    input logic [COUNTER_WIDTH-1:0] value,
    input logic                     en
  );
    if (!en) begin
      return {1'b0, value};
    end else if (value == CNT_MAX) begin
      return {1'b1, value};
    end else begin
      return {1'b0, value + COUNTER_WIDTH'(1)};
    end
  endfunction

  logic chan_level, chan_rise, chan_fall;
  logic lower_level, lower_rise, lower_fall;
  logic upper_level, upper_rise, upper_fall;

  messbauer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_channel (
    .aclk(aclk), .areset(areset), .din(channel),
    .level(chan_level), .rise(chan_rise), .fall(chan_fall)
  );

  messbauer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lower (
    .aclk(aclk), .areset(areset), .din(lower_threshold),
    .level(lower_level), .rise(lower_rise), .fall(lower_fall)
  );

  messbauer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_upper (
    .aclk(aclk), .areset(areset), .din(upper_threshold),
    .level(upper_level), .rise(upper_rise), .fall(upper_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, chan_level, chan_fall, upper_fall};

  disc_state_t                state_r, state_next;
  logic [DUR_W-1:0]           dur_r;
  logic                       armed_r, close_r;
  logic                       accept_s, reject_s, perr_s, dur_clr_s;
  logic                       acc_pend_r, rej_pend_r;
  logic [COUNTER_WIDTH-1:0]   acc_r, rej_r;
  logic                       ovf_r;
  logic [COUNTER_WIDTH:0]     acc_inc_s, rej_inc_s;
  logic                       ovf_any_s;

  // Arming on the first channel edge; later edges request a channel close.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      armed_r <= 1'b0;
      close_r <= 1'b0;
    end else begin
      close_r <= chan_rise & armed_r;
      if (chan_rise) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Pulse classification state and pulse-duration counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
      dur_r   <= '0;
    end else begin
      state_r <= state_next;
      if (dur_clr_s) begin
        dur_r <= '0;
      end else if (state_r == ST_LOWER_HIGH || state_r == ST_UPPER_SEEN) begin
        dur_r <= dur_r + DUR_W'(1);
      end else begin
        dur_r <= dur_r;
      end
    end
  end

  // Next-state and event decisions; a falling lower wins over the duration limit.
  always_comb begin
    state_next = state_r;
    accept_s   = 1'b0;
    reject_s   = 1'b0;
    perr_s     = 1'b0;
    dur_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (armed_r && lower_rise) begin
          state_next = ST_LOWER_HIGH;
          dur_clr_s  = 1'b1;
        end else if (armed_r && upper_rise) begin
          perr_s = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOWER_HIGH: begin
        if (lower_fall) begin
          state_next = ST_IDLE;
          if (upper_level) begin
            reject_s = 1'b1;
          end else begin
            accept_s = 1'b1;
          end
        end else if (dur_r == DUR_LAST) begin
          state_next = ST_ABORT;
          perr_s     = 1'b1;
        end else if (upper_level) begin
          state_next = ST_UPPER_SEEN;
        end else begin
          state_next = ST_LOWER_HIGH;
        end
      end
      ST_UPPER_SEEN: begin
        if (lower_fall) begin
          state_next = ST_IDLE;
          reject_s   = 1'b1;
        end else if (dur_r == DUR_LAST) begin
          state_next = ST_ABORT;
          perr_s     = 1'b1;
        end else begin
          state_next = ST_UPPER_SEEN;
        end
      end
      ST_ABORT: begin
        if (!lower_level) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ABORT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign acc_inc_s = sat_inc(acc_r, acc_pend_r);
  assign rej_inc_s = sat_inc(rej_r, rej_pend_r);
  assign ovf_any_s = ovf_r | acc_inc_s[COUNTER_WIDTH] | rej_inc_s[COUNTER_WIDTH];

  // Event counters; a close publishes them including any same-cycle increment.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_pend_r     <= 1'b0;
      rej_pend_r     <= 1'b0;
      acc_r          <= '0;
      rej_r          <= '0;
      ovf_r          <= 1'b0;
      channel_count  <= '0;
      rejected_count <= '0;
      count_valid    <= 1'b0;
      overflow       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      acc_pend_r     <= accept_s;
      rej_pend_r     <= reject_s;
      protocol_error <= perr_s;
      count_valid    <= close_r;
      if (close_r) begin
        channel_count  <= acc_inc_s[COUNTER_WIDTH-1:0];
        rejected_count <= rej_inc_s[COUNTER_WIDTH-1:0];
        overflow       <= ovf_any_s;
        acc_r          <= '0;
        rej_r          <= '0;
        ovf_r          <= 1'b0;
      end else begin
        acc_r <= acc_inc_s[COUNTER_WIDTH-1:0];
        rej_r <= rej_inc_s[COUNTER_WIDTH-1:0];
        ovf_r <= ovf_any_s;
      end
    end
  end

endmodule

// File: tb/tb_messbauer_diff_discriminator_counter.sv
// Self-checking bench: table-driven channel tests, hand-written corner cases
// and randomized channels checked against an event-level reference model.
module tb_messbauer_diff_discriminator_counter;

  logic aclk = 1'b0;
  logic areset, channel, lower_threshold, upper_threshold;
  logic [15:0] cc_w, rc_w;
  logic cv_w, ov_w, pe_w;
  logic [3:0] cc_n, rc_n;
  logic cv_n, ov_n, pe_n;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int cvn_cnt = 0;
  int perr_cnt = 0;

  messbauer_diff_discriminator_counter dut_w (
    .aclk(aclk), .areset(areset), .channel(channel),
    .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
    .channel_count(cc_w), .rejected_count(rc_w), .count_valid(cv_w),
    .overflow(ov_w), .protocol_error(pe_w)
  );

  messbauer_diff_discriminator_counter #(.COUNTER_WIDTH(4)) dut_n (
    .aclk(aclk), .areset(areset), .channel(channel),
    .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
    .channel_count(cc_n), .rejected_count(rc_n), .count_valid(cv_n),
    .overflow(ov_n), .protocol_error(pe_n)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (cv_w) cv_cnt <= cv_cnt + 1;
    if (cv_n) cvn_cnt <= cvn_cnt + 1;
    if (pe_w) perr_cnt <= perr_cnt + 1;
  end

  typedef struct {
    int n_acc; int n_rej;
    int e_acc; int e_rej;
    int e_acc4; int e_rej4; int e_ovf4;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_window(input int len);
    lower_threshold = 1'b1; tick(len);
    lower_threshold = 1'b0; tick(8);
  endtask

  task automatic pulse_reject();
    lower_threshold = 1'b1; tick(2);
    upper_threshold = 1'b1; tick(1);
    upper_threshold = 1'b0; tick(1);
    lower_threshold = 1'b0; tick(8);
  endtask

  task automatic upper_alone();
    upper_threshold = 1'b1; tick(2);
    upper_threshold = 1'b0; tick(8);
  endtask

  task automatic arm();
    channel = 1'b1; tick(2);
    channel = 1'b0; tick(10);
  endtask

  task automatic close_check(input string name, input int ea, input int er,
                             input int ea4, input int er4, input int eo4);
    int b, bn;
    b = cv_cnt; bn = cvn_cnt;
    channel = 1'b1; tick(2);
    channel = 1'b0; tick(10);
    check({name, "/valid_pulses"}, cv_cnt - b, 1);
    check({name, "/valid_pulses4"}, cvn_cnt - bn, 1);
    check({name, "/channel_count"}, cc_w, ea);
    check({name, "/rejected_count"}, rc_w, er);
    check({name, "/overflow"}, ov_w, 0);
    check({name, "/channel_count4"}, cc_n, ea4);
    check({name, "/rejected_count4"}, rc_n, er4);
    check({name, "/overflow4"}, ov_n, eo4);
  endtask

  initial begin
    int p0, b, first, ea, er, ep, n, kind;

    tbl[0] = '{5, 0, 5, 0, 5, 0, 0};
    tbl[1] = '{0, 4, 0, 4, 0, 4, 0};
    tbl[2] = '{3, 2, 3, 2, 3, 2, 0};
    tbl[3] = '{20, 0, 20, 0, 15, 0, 1};
    tbl[4] = '{2, 0, 2, 0, 2, 0, 0};
    tbl[5] = '{0, 17, 0, 17, 0, 15, 1};
    tbl[6] = '{1, 1, 1, 1, 1, 1, 0};

    areset = 1'b1; channel = 1'b0; lower_threshold = 1'b0; upper_threshold = 1'b0;
    tick(3);
    check("reset/channel_count", cc_w, 0);
    check("reset/rejected_count", rc_w, 0);
    check("reset/count_valid", cv_w, 0);
    check("reset/overflow", ov_w, 0);
    check("reset/protocol_error", pe_w, 0);
    areset = 1'b0;
    tick(2);
    check("post_reset/count_valid", cv_w, 0);
    check("post_reset/channel_count4", cc_n, 0);

    // Events before the first channel edge are ignored.
    pulse_window(3); pulse_window(3); pulse_reject(); upper_alone();
    check("prearm/protocol_error", perr_cnt, 0);
    check("prearm/count_valid", cv_cnt, 0);
    arm();
    check("arm/no_count_valid", cv_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].n_acc; k++) pulse_window(3);
      for (int k = 0; k < tbl[i].n_rej; k++) pulse_reject();
      close_check($sformatf("table%0d", i), tbl[i].e_acc, tbl[i].e_rej,
                  tbl[i].e_acc4, tbl[i].e_rej4, tbl[i].e_ovf4);
    end

    // Raw channel edge to count_valid latency.
    first = 0;
    channel = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (cv_w && first == 0) first = k;
    end
    channel = 1'b0; tick(6);
    check("latency/count_valid", first, 4);

    // Over-long pulse aborts once; the next normal pulse still counts.
    p0 = perr_cnt;
    pulse_window(40);
    check("long/protocol_error", perr_cnt - p0, 1);
    pulse_window(3);
    close_check("long", 1, 0, 1, 0, 0);

    // Lower falls together with the channel edge: counted in closing channel.
    b = cv_cnt;
    lower_threshold = 1'b1; tick(4);
    lower_threshold = 1'b0; channel = 1'b1; tick(2);
    channel = 1'b0; tick(10);
    check("aligned/valid_pulses", cv_cnt - b, 1);
    check("aligned/channel_count", cc_w, 1);
    close_check("after_aligned", 0, 0, 0, 0, 0);

    // Randomized channels against the event-level model.
    for (int c = 0; c < 6; c++) begin
      ea = 0; er = 0; ep = 0;
      p0 = perr_cnt;
      n = $urandom_range(3, 10);
      for (int k = 0; k < n; k++) begin
        kind = $urandom_range(0, 4);
        case (kind)
          0, 1: begin pulse_window($urandom_range(2, 8)); ea++; end
          2: begin pulse_reject(); er++; end
          3: begin upper_alone(); ep++; end
          default: begin pulse_window(40); ep++; end
        endcase
      end
      close_check($sformatf("random%0d", c), ea, er, ea, er, 0);
      check($sformatf("random%0d/protocol_error", c), perr_cnt - p0, ep);
    end

    // Reset in mid-pulse; lower still high at release must not count.
    lower_threshold = 1'b1; tick(3);
    areset = 1'b1; tick(2);
    areset = 1'b0;
    check("midreset/channel_count", cc_w, 0);
    p0 = perr_cnt;
    tick(5);
    arm();
    lower_threshold = 1'b0; tick(8);
    check("midreset/protocol_error", perr_cnt - p0, 0);
    close_check("midreset", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/messbauer_diff_discriminator_counter.md
MESSBAUER_DIFF_DISCRIMINATOR_COUNTER -- requirements
Module: messbauer_diff_discriminator_counter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16: width of all count outputs and internal counters.
REQ-002 Parameter MAX_PULSE_DURATION, default 32: longest legal lower_threshold high time, in aclk cycles.
REQ-003 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer; legal range is 2..4.
REQ-004 aclk  input  1  single system clock; all logic is on the rising edge.
REQ-005 areset  input  1  reset, asynchronous and active-high.
REQ-006 channel  input  1  asynchronous channel-advance strobe; each rising edge marks a channel boundary.
REQ-007 lower_threshold  input  1  asynchronous discriminator lower-level output.
REQ-008 upper_threshold  input  1  asynchronous discriminator upper-level output.
REQ-009 channel_count  output  COUNTER_WIDTH  accepted (window) events in the last closed channel.
REQ-010 rejected_count  output  COUNTER_WIDTH  events in the last closed channel that crossed the upper threshold.
REQ-011 count_valid  output  1  one-cycle pulse when channel_count and rejected_count update.
REQ-012 overflow  output  1  sticky flag: a counter saturated in the last closed channel.
REQ-013 protocol_error  output  1  one-cycle pulse on an illegal input sequence.

Function
REQ-014 Synchronizer: each of channel, lower_threshold and upper_threshold SHALL pass through SYNC_STAGES flops, then a one-flop edge detector.
REQ-015 Arming: event counting SHALL be disabled until the first synchronized channel rising edge; before that, events are ignored.
REQ-016 State machine SHALL have four states: IDLE, LOWER_HIGH, UPPER_SEEN, ABORT.
REQ-017 IDLE -> LOWER_HIGH on a synchronized lower rising edge; the duration counter is cleared.
REQ-018 LOWER_HIGH -> UPPER_SEEN when synchronized upper is high.
REQ-019 LOWER_HIGH -> IDLE on a synchronized lower falling edge; the accepted counter increments the next cycle.
REQ-020 UPPER_SEEN -> IDLE on a synchronized lower falling edge; the rejected counter increments the next cycle.
REQ-021 LOWER_HIGH or UPPER_SEEN -> ABORT when the duration counter reaches MAX_PULSE_DURATION; protocol_error pulses and no counter changes.
REQ-022 ABORT -> IDLE once synchronized lower is low.
REQ-023 Synchronized upper high while in IDLE SHALL pulse protocol_error once per upper rising edge; the state is unchanged.
REQ-024 Simultaneous lower falling and upper rising edges SHALL count as rejected.
REQ-025 Counters SHALL saturate at 2^COUNTER_WIDTH-1 and not wrap; saturation sets an internal overflow bit.
REQ-026 Channel close: on a synchronized channel rising edge (after arming), the following SHALL happen on the next cycle:
- both counters load into the output registers;
- overflow takes the internal overflow bit;
- count_valid pulses;
- the counters and the internal overflow bit clear.
REQ-027 An event increment due in the same cycle as a channel close SHALL be included in the closing channel's outputs.
REQ-028 A pulse in progress at channel close SHALL be counted in the channel in which lower falls.
REQ-029 Latency: raw lower falling edge to counter update is SYNC_STAGES+2 cycles. Raw channel edge to count_valid is SYNC_STAGES+2 cycles.

Reset
REQ-030 Reset SHALL clear the following; reset mid-pulse discards the pulse:
- all synchronizer flops;
- state to IDLE;
- counters, the armed flag and the overflow bits;
- channel_count, rejected_count, count_valid, overflow and protocol_error to 0.
REQ-031 After reset deassertion, a lower_threshold already high SHALL NOT produce an event, because no rising edge has been seen.

Structure
REQ-032 Package messbauer_pkg SHALL hold the state encodings and the default widths, shared with the discriminator signal generator.
REQ-033 A sub-module messbauer_sync_edge (synchronizer plus rise/fall detect, width 1) SHALL be instantiated three times.

Verification
REQ-034 Arm, then 5 window pulses (lower high 3 cycles, no upper), then close -> channel_count=5, rejected_count=0, one count_valid.
REQ-035 Arm, then 4 pulses with upper high 1 cycle inside lower, then close -> rejected_count=4, channel_count=0.
REQ-036 Lower held high 40 cycles (MAX_PULSE_DURATION=32) -> exactly one protocol_error pulse and no count change; the next normal pulse is accepted.
REQ-037 COUNTER_WIDTH=4, 20 window pulses, close -> channel_count=15 and overflow=1; the next channel with 2 pulses gives 2 and overflow=0.
REQ-038 Lower falling edge aligned so the increment coincides with the channel-close cycle -> event appears in the closing channel's channel_count.
REQ-039 Assert areset mid-pulse, release with lower still high, then lower falls -> no count and no protocol_error.
